// File: rtl/data_mem_master.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_master
// Description : Requester side of the word-addressed data memory port.
//               Takes byte/half/word loads and stores from the execute stage
//               over a valid/ready handshake. It issues them to a memory with
//               a combinational read and a clocked write. Sub-word stores use
//               read-modify-write. Misaligned, illegal-size and out-of-range
//               accesses get an error response and never touch memory.
// Ports       : clk, rst                      - clock, sync active-high reset
//               req_valid/req_ready           - request handshake
//               req_write/size/unsigned/addr/wdata - request fields
//               resp_valid/resp_ready         - response handshake
//               resp_rdata/resp_error         - response payload
//               mem_read_addr/mem_read_data   - memory read port (comb)
//               mem_write_enable/addr/data    - memory write port
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_master #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 32,
  parameter int MEM_LEN   = 1024,
  parameter int IDX_W     = $clog2(MEM_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [DATA_SIZE-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [DATA_SIZE-1:0] resp_rdata,
  output logic                 resp_error,
  output logic [IDX_W-1:0]     mem_read_addr,
  input  logic [DATA_SIZE-1:0] mem_read_data,
  output logic                 mem_write_enable,
  output logic [IDX_W-1:0]     mem_write_addr,
  output logic [DATA_SIZE-1:0] mem_write_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [ADDR_SIZE-3:0] C_MEM_LEN = (ADDR_SIZE-2)'(MEM_LEN);

  logic [1:0]           state, state_nxt;

  // Request fields held for the whole transaction
  logic                 op_write;
  logic [1:0]           op_size;
  logic                 op_unsigned;
  logic [1:0]           op_lane;
  logic [DATA_SIZE-1:0] op_wdata;
  logic [IDX_W-1:0]     op_idx;
  logic [DATA_SIZE-1:0] cap_word;
  logic [IDX_W-1:0]     rd_addr;
  logic [DATA_SIZE-1:0] rdata_q;
  logic                 error_q;

  logic                 accept;
  logic                 req_err;
  logic                 req_needs_read;
  logic [DATA_SIZE-1:0] load_val;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign accept = (state == S_IDLE) && req_valid && !rst;

  always_comb begin
    req_err = 1'b0;
    if (req_size == SZ_ILL)                              req_err = 1'b1;
    if ((req_size == SZ_HALF) && req_addr[0])            req_err = 1'b1;
    if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) req_err = 1'b1;
    if (req_addr[ADDR_SIZE-1:2] >= C_MEM_LEN)            req_err = 1'b1;
  end

  // Loads and sub-word stores both need the current memory word
  assign req_needs_read = !req_err && !(req_write && (req_size == SZ_WORD));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_err)             state_nxt = S_RESP;
          else if (req_needs_read) state_nxt = S_READ;
          else                     state_nxt = S_WRITE;
        end
      end
      S_READ:  state_nxt = op_write ? S_WRITE : S_RESP;
      S_WRITE: state_nxt = S_RESP;
      S_RESP:  if (resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready        = (state == S_IDLE) && !rst;
    resp_valid       = (state == S_RESP);
    // Gating with rst keeps a store that is interrupted by reset from committing
    mem_write_enable = (state == S_WRITE) && !rst;
    mem_write_addr   = op_idx;
    mem_read_addr    = rd_addr;
    resp_rdata       = rdata_q;
    resp_error       = error_q;
    mem_write_data   = cap_word;
    case (op_size)
      SZ_WORD: mem_write_data = op_wdata;
      SZ_HALF: begin
        if (op_lane[1]) mem_write_data[31:16] = op_wdata[15:0];
        else            mem_write_data[15:0]  = op_wdata[15:0];
      end
      SZ_BYTE: begin
        case (op_lane)
          2'd0:    mem_write_data[7:0]   = op_wdata[7:0];
          2'd1:    mem_write_data[15:8]  = op_wdata[7:0];
          2'd2:    mem_write_data[23:16] = op_wdata[7:0];
          default: mem_write_data[31:24] = op_wdata[7:0];
        endcase
      end
      default: mem_write_data = cap_word;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load lane extraction from the word being read this cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    case (op_lane)
      2'd0:    ld_byte = mem_read_data[7:0];
      2'd1:    ld_byte = mem_read_data[15:8];
      2'd2:    ld_byte = mem_read_data[23:16];
      default: ld_byte = mem_read_data[31:24];
    endcase
    ld_half = op_lane[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (op_size)
      SZ_BYTE: load_val = {{(DATA_SIZE-8){ld_byte[7] & ~op_unsigned}}, ld_byte};
      SZ_HALF: load_val = {{(DATA_SIZE-16){ld_half[15] & ~op_unsigned}}, ld_half};
      default: load_val = mem_read_data;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      op_write    <= 1'b0;
      op_size     <= SZ_BYTE;
      op_unsigned <= 1'b0;
      op_lane     <= 2'd0;
      op_wdata    <= '0;
      op_idx      <= '0;
      cap_word    <= '0;
      rd_addr     <= '0;
      rdata_q     <= '0;
      error_q     <= 1'b0;
    end else begin
      if (accept) begin
        op_write    <= req_write;
        op_size     <= req_size;
        op_unsigned <= req_unsigned;
        op_lane     <= req_addr[1:0];
        op_wdata    <= req_wdata;
        op_idx      <= req_addr[IDX_W+1:2];
        rdata_q     <= '0;
        error_q     <= req_err;
        // Read address only moves for accesses that actually read
        if (req_needs_read) rd_addr <= req_addr[IDX_W+1:2];
      end
      if (state == S_READ) begin
        cap_word <= mem_read_data;
        if (!op_write) rdata_q <= load_val;
      end
      if ((state == S_RESP) && resp_ready) begin
        rdata_q <= '0;
        error_q <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_master
// Description : Directed bench for data_mem_master with a behavioural
//               1024-word memory. Expected values are hand-computed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_error;
  logic [31:0] resp_rdata;
  logic [9:0]  mem_read_addr, mem_write_addr;
  logic [31:0] mem_read_data, mem_write_data;
  logic        mem_write_enable;

  logic [31:0] mem [0:1023];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          wr_cyc = 0;
  int          acc_cyc = 0;

  always #5 clk = ~clk;

  data_mem_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
    .mem_write_enable(mem_write_enable), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data)
  );

  assign mem_read_data = mem[mem_read_addr];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (mem_write_enable) begin
      mem[mem_write_addr] <= mem_write_data;
      wr_cnt = wr_cnt + 1;
      wr_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request, measure accept-to-resp_valid latency, check payload,
  // then complete the handshake (resp_ready is assumed high).
  task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_lat, input logic [31:0] exp_rd,
                        input logic exp_err, input string tag);
    int lat;
    @(negedge clk);
    req_write = w; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".rdata"}, resp_rdata, exp_rd);
    check({tag, ".err"}, 32'(resp_error), 32'(exp_err));
    @(posedge clk); #1;
    check({tag, ".done"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    int wc;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b10;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready",  32'(req_ready), 32'd0);
    check("rst.rvalid", 32'(resp_valid), 32'd0);
    check("rst.rdata",  resp_rdata, 32'h0);
    check("rst.err",    32'(resp_error), 32'd0);
    check("rst.wen",    32'(mem_write_enable), 32'd0);
    check("rst.raddr",  32'(mem_read_addr), 32'd0);
    check("rst.waddr",  32'(mem_write_addr), 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    check("rst.ready_after", 32'(req_ready), 32'd1);

    // Word load
    mem[5] = 32'h8000_00F0;
    do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 2, 32'h8000_00F0, 1'b0, "lw");

    // Sub-word loads
    mem[5] = 32'h1234_80F0;
    do_req(1'b0, 2'b00, 1'b0, 32'h14, 32'h0, 2, 32'hFFFF_FFF0, 1'b0, "lb");
    do_req(1'b0, 2'b00, 1'b1, 32'h15, 32'h0, 2, 32'h0000_0080, 1'b0, "lbu");
    do_req(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 2, 32'h0000_1234, 1'b0, "lh_hi");
    do_req(1'b0, 2'b01, 1'b0, 32'h14, 32'h0, 2, 32'hFFFF_80F0, 1'b0, "lh_lo");
    do_req(1'b0, 2'b01, 1'b1, 32'h14, 32'h0, 2, 32'h0000_80F0, 1'b0, "lhu");
    do_req(1'b0, 2'b00, 1'b0, 32'h17, 32'h0, 2, 32'h0000_0012, 1'b0, "lb3");

    // Sub-word stores (read-modify-write)
    mem[2] = 32'hAABB_CCDD;
    wc = wr_cnt;
    do_req(1'b1, 2'b00, 1'b0, 32'h0B, 32'h0000_0011, 3, 32'h0, 1'b0, "sb");
    check("sb.wcnt", 32'(wr_cnt - wc), 32'd1);
    check("sb.wcyc", 32'(wr_cyc - acc_cyc), 32'd2);
    check("sb.mem",  mem[2], 32'h11BB_CCDD);
    do_req(1'b1, 2'b01, 1'b0, 32'h08, 32'hFFFF_5566, 3, 32'h0, 1'b0, "sh");
    check("sh.mem",  mem[2], 32'h11BB_5566);
    mem[3] = 32'h0;
    wc = wr_cnt;
    do_req(1'b1, 2'b10, 1'b0, 32'h0C, 32'hCAFE_F00D, 2, 32'h0, 1'b0, "sw");
    check("sw.wcnt", 32'(wr_cnt - wc), 32'd1);
    check("sw.wcyc", 32'(wr_cyc - acc_cyc), 32'd1);
    check("sw.mem",  mem[3], 32'hCAFE_F00D);
    do_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 2, 32'h11BB_5566, 1'b0, "lw_back");

    // Error responses: never write
    wc = wr_cnt;
    do_req(1'b0, 2'b10, 1'b0, 32'h02,   32'h0, 1, 32'h0, 1'b1, "e_lw_mis");
    do_req(1'b1, 2'b01, 1'b0, 32'h01,   32'h1, 1, 32'h0, 1'b1, "e_sh_mis");
    do_req(1'b0, 2'b11, 1'b0, 32'h00,   32'h0, 1, 32'h0, 1'b1, "e_size");
    do_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 1, 32'h0, 1'b1, "e_range");
    do_req(1'b1, 2'b00, 1'b0, 32'h1000, 32'h5, 1, 32'h0, 1'b1, "e_sb_range");
    do_req(1'b1, 2'b10, 1'b0, 32'h0E,   32'h7, 1, 32'h0, 1'b1, "e_sw_mis");
    check("err.wcnt", 32'(wr_cnt - wc), 32'd0);
    check("err.mem0", mem[0], 32'h0);

    // Backpressure: response held for 5 cycles, no new accept
    mem[7] = 32'h0BAD_F00D;
    resp_ready = 1'b0;
    @(negedge clk);
    req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h1C; req_valid = 1'b1;
    @(posedge clk); #1;
    req_addr = 32'h14;  // second request stays pending during backpressure
    @(posedge clk); #1;
    check("bp.valid0", 32'(resp_valid), 32'd1);
    check("bp.rdata0", resp_rdata, 32'h0BAD_F00D);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp.hold_valid", 32'(resp_valid), 32'd1);
      check("bp.hold_rdata", resp_rdata, 32'h0BAD_F00D);
      check("bp.hold_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp.taken", 32'(resp_valid), 32'd0);
    check("bp.ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;   // pending request accepted here
    req_valid = 1'b0;
    check("bp.next_busy", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("bp.next_valid", 32'(resp_valid), 32'd1);
    check("bp.next_rdata", resp_rdata, 32'h1234_80F0);
    @(posedge clk); #1;

    // Reset in the middle of a word store
    mem[4] = 32'h0102_0304;
    wc = wr_cnt;
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b10; req_addr = 32'h10;
    req_wdata = 32'hDEAD_BEEF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mr.wen_pre", 32'(mem_write_enable), 32'd1);
    rst = 1'b1; #1;
    check("mr.wen_rst", 32'(mem_write_enable), 32'd0);
    @(posedge clk); #1;
    check("mr.rvalid", 32'(resp_valid), 32'd0);
    check("mr.rdata",  resp_rdata, 32'h0);
    check("mr.err",    32'(resp_error), 32'd0);
    check("mr.ready",  32'(req_ready), 32'd0);
    check("mr.wcnt",   32'(wr_cnt - wc), 32'd0);
    check("mr.mem",    mem[4], 32'h0102_0304);
    @(negedge clk); rst = 1'b0; #1;
    check("mr.ready_after", 32'(req_ready), 32'd1);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 32'h0102_0304, 1'b0, "mr.lw");
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 2, 32'h0, 1'b0, "mr.sw");
    check("mr.mem_after", mem[4], 32'hDEAD_BEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
